// File: rtl/spart_rx.sv
//------------------------------------------------------------------------------
// spart_rx
// 8N1 serial receiver for the SPART. Runs off the 16x oversample enable from
// the baud-rate generator, qualifies the start bit at its midpoint, samples
// every data bit and the stop bit at mid-bit, and hands the completed byte to
// the bus interface with a data-available flag plus framing/overrun status.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module spart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 brg_en,
    input  logic                 rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    // Tick counter is exactly log2(OVERSAMPLE) wide so it wraps on its own at
    // the end of every bit period. The bit counter needs room for DATA_BITS.
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    // Mid start bit is half a bit period after the falling edge was seen;
    // from there every further mid-bit point is one full bit period away.
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_ZERO  = BIT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;

    logic                   rxd_meta_r;
    logic                   rxd_sync_r;
    logic                   rxd_s;

    logic [TICK_W-1:0]      tick_cnt_r;
    logic [BIT_W-1:0]       bit_cnt_r;
    logic [DATA_BITS-1:0]   shift_r;

    logic [DATA_BITS-1:0]   rx_data_r;
    logic                   rda_r;
    logic                   framing_err_r;
    logic                   overrun_r;

    logic                   tick_last_s;
    logic                   sample_data_s;
    logic                   frame_done_s;

    //--------------------------------------------------------------------------
    // Input synchronizer
    //--------------------------------------------------------------------------

    // Two-flop synchronizer for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
        end
    end

    assign rxd_s = rxd_sync_r;

    //--------------------------------------------------------------------------
    // Sampling strobes
    //--------------------------------------------------------------------------

    // Decode the mid-bit sampling points of the data and stop bits.
    always_comb begin
        tick_last_s   = (tick_cnt_r == TICK_LAST);
        sample_data_s = 1'b0;
        frame_done_s  = 1'b0;
        if (brg_en && tick_last_s) begin
            sample_data_s = (state_r == ST_DATA);
            frame_done_s  = (state_r == ST_STOP);
        end else begin
            sample_data_s = 1'b0;
            frame_done_s  = 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the FSM only moves on oversample ticks, so it simply
    // freezes while brg_en is held low.
    always_comb begin
        state_s = state_r;
        if (brg_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_cnt_r == TICK_MID) begin
                        // Still low at mid start bit: a real start. Otherwise
                        // it was a glitch and we drop back silently.
                        if (!rxd_s) begin
                            state_s = ST_DATA;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (tick_last_s && (bit_cnt_r == BIT_LAST)) begin
                        state_s = ST_STOP;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_STOP: begin
                    if (tick_last_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_STOP;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Output decode: busy whenever a frame is in progress.
    always_comb begin
        rx_busy = (state_r != ST_IDLE);
    end

    //--------------------------------------------------------------------------
    // Bit timing and shift register
    //--------------------------------------------------------------------------

    // Tick/bit counters and the LSB-first shift register, advanced on ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_r <= TICK_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            shift_r    <= {DATA_BITS{1'b0}};
        end else if (brg_en) begin
            case (state_r)
                ST_IDLE: begin
                    tick_cnt_r <= TICK_ZERO;
                    bit_cnt_r  <= BIT_ZERO;
                end
                ST_START: begin
                    if (tick_cnt_r == TICK_MID) begin
                        tick_cnt_r <= TICK_ZERO;
                        bit_cnt_r  <= BIT_ZERO;
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TICK_ONE;
                    end
                end
                ST_DATA: begin
                    // Wraps from TICK_LAST to zero, which also gives the
                    // STOP state a fresh count after the last data bit.
                    tick_cnt_r <= tick_cnt_r + TICK_ONE;
                    if (sample_data_s) begin
                        shift_r   <= {rxd_s, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= bit_cnt_r + BIT_ONE;
                    end else begin
                        shift_r   <= shift_r;
                    end
                end
                ST_STOP: begin
                    tick_cnt_r <= tick_cnt_r + TICK_ONE;
                end
                default: begin
                    tick_cnt_r <= TICK_ZERO;
                    bit_cnt_r  <= BIT_ZERO;
                end
            endcase
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    //--------------------------------------------------------------------------
    // Receive holding register and status flags
    //--------------------------------------------------------------------------

    // Frame completion loads the byte and status; otherwise an ack of pending
    // data clears rda and overrun. Completion takes priority over an ack in
    // the same cycle, and an ack on that cycle prevents the overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_r     <= {DATA_BITS{1'b0}};
            rda_r         <= 1'b0;
            framing_err_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else if (frame_done_s) begin
            rx_data_r     <= shift_r;
            rda_r         <= 1'b1;
            framing_err_r <= ~rxd_s;
            overrun_r     <= ~rx_ack & (overrun_r | rda_r);
        end else if (rx_ack && rda_r) begin
            rda_r         <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            rda_r         <= rda_r;
            overrun_r     <= overrun_r;
        end
    end

    assign rx_data     = rx_data_r;
    assign rda         = rda_r;
    assign framing_err = framing_err_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_spart_rx.sv
//------------------------------------------------------------------------------
// tb_spart_rx
// Directed bench for spart_rx: brg_en every 4 clk (64 clk per bit). Frames are
// pushed to a scoreboard when transmitted; a monitor pops and compares them
// when the receiver finishes a frame (rx_busy falls after a full frame).
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spart_rx;

    localparam int BIT_CLKS    = 64;
    localparam int FULL_TICKS  = 151;   // brg ticks after start detection before the completing tick

    logic       clk;
    logic       rst;
    logic       brg_en;
    logic       rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       overrun;
    logic       rx_busy;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t sb[$];
    int   errors;
    int   checks;
    int   brg_div;
    logic mon_prev_busy;
    int   mon_ticks;
    exp_t mon_e;

    spart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .brg_en      (brg_en),
        .rxd         (rxd),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rda         (rda),
        .framing_err (framing_err),
        .overrun     (overrun),
        .rx_busy     (rx_busy)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample enable: one clk wide, every fourth clock, changed on negedges.
    initial begin
        brg_en  = 1'b0;
        brg_div = 0;
        forever begin
            @(negedge clk);
            brg_div = (brg_div + 1) % 4;
            brg_en  = (brg_div == 3);
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: count brg ticks while busy; a busy fall after a full frame is a completion.
    initial begin
        mon_prev_busy = 1'b0;
        mon_ticks     = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                mon_prev_busy = 1'b0;
                mon_ticks     = 0;
            end else begin
                if (rx_busy && !mon_prev_busy) begin
                    mon_ticks = 0;
                end else if (rx_busy && brg_en) begin
                    mon_ticks++;
                end
                if (mon_prev_busy && !rx_busy && mon_ticks >= 100) begin
                    check("sb_nonempty", (sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        check("frame_data", rx_data, mon_e.data);
                        check("frame_rda", rda, 1);
                        check("frame_ferr", framing_err, mon_e.ferr);
                        check("frame_ovr", overrun, mon_e.ovr);
                    end
                end
                mon_prev_busy = rx_busy;
            end
        end
    end

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Send one 8N1 frame and push its expected result; optional ack late in the stop bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic ack_mid, input logic ovr_exp);
        exp_t e;
        e.data = data;
        e.ferr = ~stop_bit;
        e.ovr  = ovr_exp;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(data[i]);
        end
        rxd = stop_bit;
        repeat (48) @(negedge clk);
        if (ack_mid) begin
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
            repeat (15) @(negedge clk);
        end else begin
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    // Raise rx_ack for exactly the clock edge on which the frame completes.
    task automatic ack_at_completion();
        int guard;
        int n;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!rx_busy && guard < 200);
        check("race_busy_seen", rx_busy, 1);
        n     = 0;
        guard = 0;
        while (n < FULL_TICKS && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
            if (brg_en) n++;
        end
        check("race_tick_count", n, FULL_TICKS);
        repeat (3) @(posedge clk);
        #1;
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        rxd    = 1'b1;
        rx_ack = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_data", rx_data, 8'h00);
        check("rst_rda", rda, 1'b0);
        check("rst_ferr", framing_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Basic byte, then ack
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check("ack_clears_rda", rda, 1'b0);
        // Ack with nothing pending is ignored
        pulse_ack();
        check("idle_ack_data", rx_data, 8'hA5);
        check("idle_ack_rda", rda, 1'b0);
        check("idle_ack_ovr", overrun, 1'b0);

        // Start glitch: low for 3 ticks
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch_busy_high", rx_busy, 1'b1);
        repeat (25) @(negedge clk);
        check("glitch_busy_low", rx_busy, 1'b0);
        check("glitch_rda", rda, 1'b0);
        check("glitch_ferr", framing_err, 1'b0);
        repeat (20) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);

        // Framing error, then a clean frame clears it
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        rxd = 1'b1;
        check("ferr_kept_after_ack", framing_err, 1'b1);
        repeat (100) @(negedge clk);
        check("ferr_idle_busy", rx_busy, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b1, 1'b0);

        // Overrun, then ack clears it
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1);
        pulse_ack();
        check("ovr_ack_rda", rda, 1'b0);
        check("ovr_ack_ovr", overrun, 1'b0);

        // Ack on the completion edge of the second frame: no overrun
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        fork
            send_frame(8'h22, 1'b1, 1'b0, 1'b0);
            ack_at_completion();
        join
        check("race_rda_kept", rda, 1'b1);
        pulse_ack();
        check("race_ack_rda", rda, 1'b0);

        // Back-to-back frames
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);

        // Reset during data bit 4 of 0xFF
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        rxd = 1'b1;
        repeat (4 * BIT_CLKS + 32) @(negedge clk);
        check("pre_rst_busy", rx_busy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_rda", rda, 1'b0);
        check("mid_rst_ferr", framing_err, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        check("mid_rst_busy", rx_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b1, 1'b0);

        repeat (20) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- 8N1 serial receiver for the SPART; sits directly downstream of the baud-rate generator.
- Consumes the generator's 16x-oversample enable (brg_en) and samples RxD at mid-bit.
- Presents each received byte with a data-available flag to the bus interface.
- Flags framing errors and overruns.

Parameters:
DATA_BITS, 8, number of data bits per frame (LSB first; one start bit, one stop bit, no parity)
OVERSAMPLE, 16, brg_en ticks per bit period; must be a power of two, >= 8

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
brg_en  input  1  oversample tick from the baud-rate generator; one clk wide; all bit timing counts only these cycles
rxd  input  1  asynchronous serial input, idle high
rx_ack  input  1  consumer has read rx_data; one clk pulse
rx_data  output  DATA_BITS  last completed byte; holds until the next frame completes
rda  output  1  receive data available
framing_err  output  1  stop bit of the last completed frame sampled low
overrun  output  1  sticky; a frame completed while rda was already set
rx_busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - FSM = IDLE; tick_cnt = 0; bit_cnt = 0; shift register = 0.
  - rx_data = 0; rda = 0; framing_err = 0; overrun = 0; rx_busy = 0.
  - Both synchronizer flops = 1.
  - Reset mid-frame discards the partial frame; no output changes other than the reset values.
- Input sync: rxd passes through a 2-flop synchronizer (rxd_s); only rxd_s is used.
- tick_cnt is log2(OVERSAMPLE) bits and wraps naturally. FSM moves and counter updates happen only on cycles with brg_en=1, except rx_ack handling.
- IDLE:
  - On brg_en with rxd_s=0: go to START, tick_cnt=0.
- START:
  - Increment tick_cnt on each brg_en.
  - When tick_cnt == OVERSAMPLE/2-1 on a brg_en cycle (mid start bit), check rxd_s:
    - rxd_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
    - rxd_s=1: glitch; return to IDLE with no flags touched.
- DATA:
  - On brg_en with tick_cnt == OVERSAMPLE-1 (mid data bit): shift rxd_s into the MSB of the shift register (right-shift, LSB received first); increment bit_cnt.
  - If this was bit DATA_BITS-1: go to STOP, tick_cnt=0.
- STOP:
  - On brg_en with tick_cnt == OVERSAMPLE-1 (mid stop bit):
    - rx_data <= shift register; rda <= 1; framing_err <= ~rxd_s.
    - overrun <= 1 if rda was already 1 and rx_ack is not high this cycle.
    - Return to IDLE. A new start bit can be detected on the next brg_en.
  - The byte is delivered even on a framing error.
- rda/flags latency: outputs are registered; they change on the clk edge that ends the sampling brg_en cycle.
- rx_ack:
  - Clears rda and overrun on the next edge.
  - Ack and frame completion in the same cycle: completion wins (rda=1, new data, overrun not set).
  - rx_ack while rda=0 is ignored.
  - framing_err is not cleared by ack; it is rewritten each completed frame.
- rx_busy is a combinational decode of state != IDLE.
- brg_en held low: FSM freezes in its current state indefinitely; no timeout.

Test Plan:
- Basic byte: brg_en every 4 clk, send 0xA5 (8N1, 64 clk/bit) -> rx_data=0xA5 and rda=1 one clk after the mid-stop sample; framing_err=0; rx_busy falls the same edge.
- Start glitch: rxd low for 3 brg_en ticks, then high -> FSM returns to IDLE at tick 7; rda stays 0; no flags; a following 0x3C frame is received correctly.
- Framing error: send 0x55 with the stop bit driven low -> rx_data=0x55, rda=1, framing_err=1; a next clean frame 0x0F clears framing_err to 0.
- Overrun and ack race:
  - Receive 0x11 with no ack, then 0x22 -> rx_data=0x22, overrun=1.
  - rx_ack -> rda=0, overrun=0.
  - Repeat with rx_ack asserted exactly on the completion cycle of the second frame -> rda=1, overrun=0.
- Reset mid-frame: drive rst low during data bit 4 of 0xFF -> all outputs 0 immediately (asynchronous); after release, frame 0x81 is received cleanly.
- Back-to-back frames: 0x00, 0xFF, 0x5A with no idle gap, rx_ack after each -> all three bytes received in order, no errors.
